// File: rtl/vga_text_console_if.sv
// rtl/vga_text_console_if.sv - character handshake and display-buffer write bus for the text console
interface vga_text_console_if #(
    parameter int ASCII_WIDTH = 8
);
    logic                   char_valid;
    logic [ASCII_WIDTH-1:0] char_data;
    logic                   char_ready;
    logic                   clear_req;
    logic                   bufferWe;
    logic [31:0]            bufferAddr;
    logic [31:0]            bufferData;

    modport master (
        output char_valid, char_data, clear_req,
        input  char_ready, bufferWe, bufferAddr, bufferData
    );

    modport slave (
        input  char_valid, char_data, clear_req,
        output char_ready, bufferWe, bufferAddr, bufferData
    );
endinterface

// File: rtl/vga_text_console.sv
// rtl/vga_text_console.sv - character-stream front end: cursor tracking and display-buffer writes
module vga_text_console #(
    parameter int GRID_COL    = 10,
    parameter int GRID_ROW    = 5,
    parameter int ASCII_WIDTH = 8,
    parameter int ADDR_WIDTH  = 11
) (
    input  logic                        clk_pix,
    input  logic                        rst_n,
    vga_text_console_if.slave           bus,
    output logic [$clog2(GRID_ROW)-1:0] cursor_row,
    output logic [$clog2(GRID_COL)-1:0] cursor_col,
    output logic                        busy
);
    localparam int CW = $clog2(GRID_COL);
    localparam int RW = $clog2(GRID_ROW);
    localparam int AW = ADDR_WIDTH;
    localparam logic [AW-1:0] COLS_A  = AW'(GRID_COL);
    localparam logic [AW-1:0] CELLS_A = AW'(GRID_COL * GRID_ROW);
    localparam logic [CW-1:0] LAST_COL = CW'(GRID_COL - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(GRID_ROW - 1);
    localparam logic [ASCII_WIDTH-1:0] SPACE = ASCII_WIDTH'(8'h20);

    typedef enum logic [1:0] {IDLE, PUT, WIPE, CLEAR_ALL} state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          col_q, col_n;
    logic [RW-1:0]          row_q, row_n;
    logic [AW-1:0]          base_q, base_n;
    logic [AW-1:0]          cnt_q, cnt_n;
    logic [AW-1:0]          addr_q, addr_n;
    logic [ASCII_WIDTH-1:0] data_q, data_n;
    logic                   bs_q, bs_n;
    logic                   pend_q, pend_n;
    logic                   we_q, we_n;
    logic                   ready_q, ready_n;
    logic                   busy_q, busy_n;
    logic [RW-1:0]          adv_row;
    logic [AW-1:0]          adv_base;
    logic                   transfer;
    logic [ASCII_WIDTH-1:0] ch;

    assign ch       = bus.char_data;
    assign transfer = bus.char_valid & ready_q;
    // Row base tracks row*GRID_COL incrementally so no multiplier is needed.
    assign adv_row  = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
    assign adv_base = (row_q == LAST_ROW) ? '0 : base_q + COLS_A;

    always_comb begin
        state_n = state;
        col_n   = col_q;
        row_n   = row_q;
        base_n  = base_q;
        cnt_n   = cnt_q;
        bs_n    = bs_q;
        we_n    = 1'b0;
        addr_n  = addr_q;
        data_n  = data_q;
        case (state)
            IDLE: begin
                if (pend_q) begin
                    state_n = CLEAR_ALL;
                    col_n   = '0;
                    row_n   = '0;
                    base_n  = '0;
                    cnt_n   = AW'(1);
                    we_n    = 1'b1;
                    addr_n  = '0;
                    data_n  = SPACE;
                end else if (transfer) begin
                    if (ch >= ASCII_WIDTH'(8'h20) && ch <= ASCII_WIDTH'(8'h7E)) begin
                        state_n = PUT;
                        bs_n    = 1'b0;
                        we_n    = 1'b1;
                        addr_n  = base_q + AW'(col_q);
                        data_n  = ch;
                    end else if (ch == ASCII_WIDTH'(8'h0D)) begin
                        col_n = '0;
                    end else if (ch == ASCII_WIDTH'(8'h0A)) begin
                        col_n   = '0;
                        row_n   = adv_row;
                        base_n  = adv_base;
                        state_n = WIPE;
                        cnt_n   = AW'(1);
                        we_n    = 1'b1;
                        addr_n  = adv_base;
                        data_n  = SPACE;
                    end else if (ch == ASCII_WIDTH'(8'h08) && col_q != '0) begin
                        col_n   = col_q - CW'(1);
                        state_n = PUT;
                        bs_n    = 1'b1;
                        we_n    = 1'b1;
                        addr_n  = base_q + AW'(col_q) - AW'(1);
                        data_n  = SPACE;
                    end
                end
            end
            PUT: begin
                if (bs_q) begin
                    state_n = IDLE;
                end else if (col_q != LAST_COL) begin
                    col_n   = col_q + CW'(1);
                    state_n = IDLE;
                end else begin
                    col_n   = '0;
                    row_n   = adv_row;
                    base_n  = adv_base;
                    state_n = WIPE;
                    cnt_n   = AW'(1);
                    we_n    = 1'b1;
                    addr_n  = adv_base;
                    data_n  = SPACE;
                end
            end
            WIPE: begin
                if (cnt_q == COLS_A) begin
                    state_n = IDLE;
                end else begin
                    we_n   = 1'b1;
                    addr_n = base_q + cnt_q;
                    cnt_n  = cnt_q + AW'(1);
                    data_n = SPACE;
                end
            end
            default: begin
                if (cnt_q == CELLS_A) begin
                    state_n = IDLE;
                end else begin
                    we_n   = 1'b1;
                    addr_n = cnt_q;
                    cnt_n  = cnt_q + AW'(1);
                    data_n = SPACE;
                end
            end
        endcase
        // A request arriving while a full clear is underway is already covered by it.
        pend_n  = (state == CLEAR_ALL || state_n == CLEAR_ALL) ? 1'b0 : (pend_q | bus.clear_req);
        ready_n = (state_n == IDLE) && !pend_n;
        busy_n  = (state_n != IDLE);
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR_ALL;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            bs_q    <= 1'b0;
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state   <= state_n;
            col_q   <= col_n;
            row_q   <= row_n;
            base_q  <= base_n;
            cnt_q   <= cnt_n;
            bs_q    <= bs_n;
            pend_q  <= pend_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            ready_q <= ready_n;
            busy_q  <= busy_n;
        end
    end

    assign bus.char_ready = ready_q;
    assign bus.bufferWe   = we_q;
    assign bus.bufferAddr = {{(32-AW){1'b0}}, addr_q};
    assign bus.bufferData = {{(32-ASCII_WIDTH){1'b0}}, data_q};
    assign cursor_row     = row_q;
    assign cursor_col     = col_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_vga_text_console.sv
// tb/tb_vga_text_console.sv - randomized self-checking bench for vga_text_console against a screen model
module tb_vga_text_console;
    localparam int COLS = 10;
    localparam int ROWS = 5;
    localparam int N    = COLS * ROWS;

    logic       clk_pix = 1'b0;
    logic       rst_n   = 1'b0;
    logic [2:0] cursor_row;
    logic [3:0] cursor_col;
    logic       busy;

    always #5 clk_pix = ~clk_pix;

    vga_text_console_if #(.ASCII_WIDTH(8)) bus ();

    vga_text_console #(
        .GRID_COL(COLS), .GRID_ROW(ROWS), .ASCII_WIDTH(8), .ADDR_WIDTH(11)
    ) dut (
        .clk_pix    (clk_pix),
        .rst_n      (rst_n),
        .bus        (bus),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    int vectors     = 0;
    int miscompares = 0;
    int exp_addr[$];
    int exp_data[$];
    int mrow = 0;
    int mcol = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every buffer write must be the next one the screen model predicts.
    always @(negedge clk_pix) begin
        if (rst_n && bus.bufferWe === 1'b1) begin
            if (exp_addr.size() == 0) begin
                chk("unexpected_write", bus.bufferAddr, 32'hFFFF_FFFF);
            end else begin
                chk("wr_addr", bus.bufferAddr, 32'(exp_addr.pop_front()));
                chk("wr_data", bus.bufferData, 32'(exp_data.pop_front()));
            end
        end
    end

    task automatic push(input int a, input int d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic push_wipe();
        for (int i = 0; i < COLS; i++) push(mrow * COLS + i, 32);
    endtask

    task automatic push_clear();
        for (int i = 0; i < N; i++) push(i, 32);
        mrow = 0;
        mcol = 0;
    endtask

    task automatic next_line();
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        push_wipe();
    endtask

    task automatic model_char(input int c);
        if (c >= 32 && c <= 126) begin
            push(mrow * COLS + mcol, c);
            if (mcol < COLS - 1) mcol++;
            else next_line();
        end else if (c == 13) begin
            mcol = 0;
        end else if (c == 10) begin
            next_line();
        end else if (c == 8 && mcol > 0) begin
            mcol--;
            push(mrow * COLS + mcol, 32);
        end
    endtask

    // Starts at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_char(input logic [7:0] c);
        int n;
        n = 0;
        bus.char_valid = 1'b1;
        bus.char_data  = c;
        while (bus.char_ready !== 1'b1 && n < 300) begin
            @(negedge clk_pix);
            n++;
        end
        if (n >= 300) chk("accept_timeout", 32'(bus.char_ready), 32'd1);
        @(posedge clk_pix);
        model_char(int'(c));
        #1 bus.char_valid = 1'b0;
        @(negedge clk_pix);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.char_ready !== 1'b1 && n < 300) begin
            @(negedge clk_pix);
            n++;
        end
        if (n >= 300) chk("ready_timeout", 32'(bus.char_ready), 32'd1);
    endtask

    task automatic check_cursor();
        chk("cursor_row", 32'(cursor_row), 32'(mrow));
        chk("cursor_col", 32'(cursor_col), 32'(mcol));
    endtask

    task automatic pulse_clear();
        bus.clear_req = 1'b1;
        push_clear();
        @(negedge clk_pix);
        bus.clear_req = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_cnt, gaps, n, lowcnt, r;
        bit started;
        logic [7:0] c;

        bus.char_valid = 1'b0;
        bus.char_data  = 8'h00;
        bus.clear_req  = 1'b0;
        repeat (3) @(negedge clk_pix);
        chk("rst_we",    32'(bus.bufferWe), 32'd0);
        chk("rst_addr",  bus.bufferAddr, 32'd0);
        chk("rst_data",  bus.bufferData, 32'd0);
        chk("rst_ready", 32'(bus.char_ready), 32'd0);
        chk("rst_busy",  32'(busy), 32'd1);
        check_cursor();

        push_clear();
        rst_n = 1'b1;
        we_cnt = 0; gaps = 0; n = 0; started = 0;
        while (bus.char_ready !== 1'b1 && n < 300) begin
            @(negedge clk_pix);
            n++;
            if (bus.bufferWe === 1'b1) begin
                we_cnt++;
                started = 1;
            end else if (started && bus.char_ready !== 1'b1) begin
                gaps++;
            end
        end
        chk("clear_writes", 32'(we_cnt), 32'd50);
        chk("clear_gaps",   32'(gaps), 32'd0);
        chk("idle_busy",    32'(busy), 32'd0);
        chk("idle_ready",   32'(bus.char_ready), 32'd1);

        send_char(8'h41);
        chk("put_latency",   32'(bus.bufferWe), 32'd1);
        chk("put_ready_low", 32'(bus.char_ready), 32'd0);
        @(negedge clk_pix);
        chk("put_ready_back", 32'(bus.char_ready), 32'd1);
        chk("put_we_low",     32'(bus.bufferWe), 32'd0);
        check_cursor();

        send_char(8'h0D);
        for (int i = 0; i < 10; i++) send_char(8'h30 + 8'(i));
        lowcnt = 0;
        while (bus.char_ready !== 1'b1 && lowcnt < 300) begin
            lowcnt++;
            @(negedge clk_pix);
        end
        chk("row_end_ready_low", 32'(lowcnt), 32'd11);
        check_cursor();

        send_char(8'h0A);
        for (int i = 0; i < 3; i++) send_char(8'h61 + 8'(i));
        send_char(8'h08);
        wait_ready();
        check_cursor();
        send_char(8'h0D);
        send_char(8'h08);
        wait_ready();
        check_cursor();

        send_char(8'h0A);
        send_char(8'h0A);
        for (int i = 0; i < 5; i++) send_char(8'h4B);
        wait_ready();
        check_cursor();
        send_char(8'h0A);
        wait_ready();
        check_cursor();
        for (int i = 0; i < 3; i++) send_char(8'h7E);
        send_char(8'h0D);
        wait_ready();
        check_cursor();

        send_char(8'h0A);
        repeat (2) @(negedge clk_pix);
        pulse_clear();
        send_char(8'h5A);
        wait_ready();
        check_cursor();
        chk("clear_queue_empty", 32'(exp_addr.size()), 32'd0);

        pulse_clear();
        repeat (20) @(negedge clk_pix);
        #2 rst_n = 1'b0;
        #1 chk("reset_we_drop", 32'(bus.bufferWe), 32'd0);
        exp_addr.delete();
        exp_data.delete();
        push_clear();
        @(negedge clk_pix);
        rst_n = 1'b1;
        wait_ready();
        check_cursor();
        chk("reclear_queue_empty", 32'(exp_addr.size()), 32'd0);

        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 15);
            if (r <= 6) c = 8'($urandom_range(32, 126));
            else if (r == 7) c = 8'h0D;
            else if (r == 8) c = 8'h0A;
            else if (r <= 10) c = 8'h08;
            else if (r == 11) c = 8'($urandom_range(0, 7));
            else if (r == 12) c = 8'($urandom_range(14, 31));
            else c = 8'($urandom_range(127, 255));
            if (r == 15) begin
                wait_ready();
                pulse_clear();
                wait_ready();
                check_cursor();
            end
            send_char(c);
            if ($urandom_range(0, 3) != 0) begin
                wait_ready();
                check_cursor();
            end
        end
        wait_ready();
        check_cursor();
        repeat (2) @(negedge clk_pix);
        chk("final_queue_empty", 32'(exp_addr.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
